// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH double-buffered PWM channels sharing one prescaler tick.
// Define PWM_MULTI_PHASE_EN to build per-channel phase (counter start) registers.
module pwm_multi #(
    parameter int NUM_CH         = 4,
    parameter int WAVE_WEIGHT    = 1024,
    parameter int WAVE_LEN_WIDTH = 11,
    parameter int CH_SEL_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      update,
    input  logic [CH_SEL_WIDTH-1:0]   ch_sel,
    input  logic [WAVE_LEN_WIDTH-1:0] wave_length,
    input  logic [WAVE_LEN_WIDTH-1:0] pulse_width,
    input  logic [WAVE_LEN_WIDTH-1:0] phase,
    input  logic                      active_high,
    input  logic [NUM_CH-1:0]         enable,
    output logic [WAVE_LEN_WIDTH-1:0] wave_length_out,
    output logic [WAVE_LEN_WIDTH-1:0] pulse_width_out,
    output logic                      active_high_out,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         period_start,
    output logic [NUM_CH-1:0]         pwm_out
);
    localparam int WCW = (WAVE_WEIGHT > 0) ? $clog2(WAVE_WEIGHT + 1) : 1;
    localparam logic [WCW-1:0] WC_MAX = WCW'(WAVE_WEIGHT);
    localparam logic [WCW-1:0] WC_ONE = WCW'(1);
    localparam logic [WAVE_LEN_WIDTH-1:0] ONE = WAVE_LEN_WIDTH'(1);
    localparam logic [CH_SEL_WIDTH:0] CH_LIM = (CH_SEL_WIDTH + 1)'(NUM_CH);

    logic [WAVE_LEN_WIDTH-1:0] wl_act [NUM_CH];
    logic [WAVE_LEN_WIDTH-1:0] pw_act [NUM_CH];
    logic [WAVE_LEN_WIDTH-1:0] wl_sh [NUM_CH];
    logic [WAVE_LEN_WIDTH-1:0] pw_sh [NUM_CH];
    logic [WAVE_LEN_WIDTH-1:0] cnt [NUM_CH];
    logic [WAVE_LEN_WIDTH-1:0] cnt_start [NUM_CH];
    logic [NUM_CH-1:0]         ah_act, ah_sh, wrap, commit;
    logic [WCW-1:0]            weight_counter;
    logic                      update_d, tick, sel_ok, wr;
`ifdef PWM_MULTI_PHASE_EN
    logic [WAVE_LEN_WIDTH-1:0] ph_act [NUM_CH];
    logic [WAVE_LEN_WIDTH-1:0] ph_sh [NUM_CH];
`else
    logic unused_phase;
    assign unused_phase = ^phase;
`endif

    always_comb begin
        sel_ok          = {1'b0, ch_sel} < CH_LIM;
        wr              = update & ~update_d & sel_ok;
        wave_length_out = sel_ok ? wl_act[ch_sel] : '0;
        pulse_width_out = sel_ok ? pw_act[ch_sel] : '0;
        active_high_out = sel_ok ? ah_act[ch_sel] : 1'b0;
    end

    // a disabled channel commits at once; an enabled one only at its wrap (or any tick while idle at wl=0)
    always_comb begin
        wrap      = '0;
        commit    = '0;
        cnt_start = '{default: '0};
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]   = tick && enable[i] && wl_act[i] != '0 && cnt[i] == wl_act[i] - ONE;
            commit[i] = pending[i] && (!enable[i] || (tick && (wl_act[i] == '0 || wrap[i])));
`ifdef PWM_MULTI_PHASE_EN
            cnt_start[i] = (ph_act[i] >= wl_act[i]) ? '0 : ph_act[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            update_d       <= 1'b1;
            tick           <= 1'b0;
            weight_counter <= '0;
            pending        <= '0;
            period_start   <= '0;
            pwm_out        <= '0;
            ah_act         <= '1;
            ah_sh          <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                wl_act[i] <= '0;
                pw_act[i] <= '0;
                wl_sh[i]  <= '0;
                pw_sh[i]  <= '0;
                cnt[i]    <= '0;
`ifdef PWM_MULTI_PHASE_EN
                ph_act[i] <= '0;
                ph_sh[i]  <= '0;
`endif
            end
        end else begin
            update_d       <= update;
            tick           <= weight_counter == '0;
            weight_counter <= (weight_counter == WC_MAX) ? '0 : weight_counter + WC_ONE;
            for (int i = 0; i < NUM_CH; i++) begin
                period_start[i] <= wrap[i];
                if (!enable[i]) begin
                    pwm_out[i] <= ~ah_act[i];
                    cnt[i]     <= cnt_start[i];
                end else if (tick) begin
                    pwm_out[i] <= (wl_act[i] != '0 && cnt[i] < pw_act[i]) ? ah_act[i] : ~ah_act[i];
                    cnt[i]     <= (wl_act[i] == '0 || wrap[i]) ? '0 : cnt[i] + ONE;
                end
                if (commit[i]) begin
                    wl_act[i]  <= wl_sh[i];
                    pw_act[i]  <= pw_sh[i];
                    ah_act[i]  <= ah_sh[i];
`ifdef PWM_MULTI_PHASE_EN
                    ph_act[i]  <= ph_sh[i];
`endif
                    pending[i] <= 1'b0;
                end
                // a write landing on the wrap edge stays pending for the next period
                if (wr && ch_sel == CH_SEL_WIDTH'(i)) begin
                    wl_sh[i]   <= wave_length;
                    pw_sh[i]   <= pulse_width;
                    ah_sh[i]   <= active_high;
`ifdef PWM_MULTI_PHASE_EN
                    ph_sh[i]   <= phase;
`endif
                    pending[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed checks of pwm_multi with a 3-clock PWM step (WAVE_WEIGHT=2).
module tb_pwm_multi;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset, update, active_high;
    logic [1:0]   ch_sel;
    logic [10:0]  wave_length, pulse_width, phase;
    logic [N-1:0] enable;
    logic [10:0]  wave_length_out, pulse_width_out;
    logic         active_high_out;
    logic [N-1:0] pending, period_start, pwm_out;

    int           checks = 0, failures = 0;
    logic [N-1:0] pwm_log [64];
    logic [N-1:0] ps_log [64];
    logic [63:0]  got, exp_v;
    bit           ok;

    pwm_multi #(.NUM_CH(N), .WAVE_WEIGHT(2), .WAVE_LEN_WIDTH(11)) dut (
        .clk(clk), .reset(reset), .update(update), .ch_sel(ch_sel),
        .wave_length(wave_length), .pulse_width(pulse_width), .phase(phase),
        .active_high(active_high), .enable(enable),
        .wave_length_out(wave_length_out), .pulse_width_out(pulse_width_out),
        .active_high_out(active_high_out), .pending(pending),
        .period_start(period_start), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic do_write(input int ch, input int wl, input int pw, input int ph, input logic ah);
        @(posedge clk); #1;
        ch_sel = 2'(ch); wave_length = 11'(wl); pulse_width = 11'(pw); phase = 11'(ph);
        active_high = ah; update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
    endtask

    task automatic config_ch(input int ch, input int wl, input int pw, input int ph, input logic ah);
        enable[ch] = 1'b0;
        do_write(ch, wl, pw, ph, ah);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input int ch, output bit found);
        int k = 0;
        found = 1'b0;
        while (!found && k < 100) begin
            @(negedge clk);
            found = period_start[ch];
            k++;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_log[i] = pwm_out;
            ps_log[i]  = period_start;
        end
    endtask

    function automatic logic [63:0] pick(input int ch, input bit ps, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = ps ? ps_log[i][ch] : pwm_log[i][ch];
        return v;
    endfunction

    task automatic test_reset;
        reset = 1'b1; update = 1'b0; enable = '0; ch_sel = '0;
        wave_length = '0; pulse_width = '0; phase = '0; active_high = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({pwm_out, period_start, pending} !== 9'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0", {pwm_out, period_start, pending});
        end
        checks++;
        if ({wave_length_out, pulse_width_out, active_high_out} !== 23'd1) begin
            failures++; $display("FAIL reset_readback got=%h exp=1", {wave_length_out, pulse_width_out, active_high_out});
        end
    endtask

    task automatic test_basic;
        do_write(0, 4, 1, 0, 1'b1);
        checks++;
        if (pending[0] !== 1'b1) begin failures++; $display("FAIL basic_pending_set got=%b exp=1", pending[0]); end
        @(posedge clk); #1;
        checks++;
        if (pending[0] !== 1'b0) begin failures++; $display("FAIL basic_pending_clear got=%b exp=0", pending[0]); end
        checks++;
        if ({wave_length_out, pulse_width_out} !== {11'd4, 11'd1}) begin
            failures++; $display("FAIL basic_readback got=%0d/%0d exp=4/1", wave_length_out, pulse_width_out);
        end
        @(posedge clk); #1;
        enable[0] = 1'b1;
        wait_ps(0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_wait_ps got=timeout exp=pulse"); end
        capture(24);
        got = pick(0, 0, 24);
        checks++;
        if (got !== 64'h01C01C) begin failures++; $display("FAIL basic_pwm got=%h exp=01c01c", got); end
        got = pick(0, 1, 24);
        checks++;
        if (got !== 64'h800800) begin failures++; $display("FAIL basic_period_start got=%h exp=800800", got); end
    endtask

    task automatic test_glitch_free;
        config_ch(1, 4, 2, 0, 1'b1);
        enable[1] = 1'b1;
        wait_ps(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL glitch_wait_ps got=timeout exp=pulse"); end
        do_write(1, 4, 3, 0, 1'b1);
        checks++;
        if (pending[1] !== 1'b1) begin failures++; $display("FAIL glitch_pending_set got=%b exp=1", pending[1]); end
        capture(10);
        got = pick(1, 0, 10);
        checks++;
        if (got !== 64'h07E) begin failures++; $display("FAIL glitch_old_period got=%h exp=07e", got); end
        checks++;
        if (pending[1] !== 1'b1) begin failures++; $display("FAIL glitch_pending_held got=%b exp=1", pending[1]); end
        wait_ps(1, ok);
        checks++;
        if (!ok || pending[1] !== 1'b0) begin
            failures++; $display("FAIL glitch_commit got=found%0d/pending%b exp=found1/pending0", ok, pending[1]);
        end
        checks++;
        if (pulse_width_out !== 11'd3) begin failures++; $display("FAIL glitch_readback got=%0d exp=3", pulse_width_out); end
        capture(12);
        got = pick(1, 0, 12);
        checks++;
        if (got !== 64'h7FC) begin failures++; $display("FAIL glitch_new_period got=%h exp=7fc", got); end
    endtask

    task automatic test_phase;
        enable = '0;
        config_ch(1, 4, 1, 0, 1'b1);
        config_ch(2, 4, 1, 2, 1'b1);
        enable = 3'b110;
        wait_ps(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL phase_wait_ps got=timeout exp=pulse"); end
        capture(12);
        got = pick(1, 0, 12);
        checks++;
        if (got !== 64'h01C) begin failures++; $display("FAIL phase_ch1 got=%h exp=01c", got); end
`ifdef PWM_MULTI_PHASE_EN
        exp_v = 64'h700;
`else
        exp_v = 64'h01C;
`endif
        got = pick(2, 0, 12);
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL phase_ch2_pwm got=%h exp=%h", got, exp_v); end
`ifdef PWM_MULTI_PHASE_EN
        exp_v = 64'h020;
`else
        exp_v = 64'h800;
`endif
        got = pick(2, 1, 12);
        checks++;
        if (got !== exp_v) begin failures++; $display("FAIL phase_ch2_ps got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_boundaries;
        enable = '0;
        config_ch(0, 4, 0, 0, 1'b1);
        enable[0] = 1'b1;
        wait_ps(0, ok);
        capture(12);
        got = pick(0, 0, 12);
        checks++;
        if (!ok || got !== 64'h000) begin failures++; $display("FAIL bound_pw0 got=%h exp=000", got); end
        got = pick(0, 1, 12);
        checks++;
        if (got !== 64'h800) begin failures++; $display("FAIL bound_pw0_ps got=%h exp=800", got); end
        config_ch(0, 4, 5, 0, 1'b1);
        enable[0] = 1'b1;
        wait_ps(0, ok);
        capture(12);
        got = pick(0, 0, 12);
        checks++;
        if (!ok || got !== 64'hFFF) begin failures++; $display("FAIL bound_pw_over got=%h exp=fff", got); end
        config_ch(0, 4, 1, 0, 1'b0);
        enable[0] = 1'b1;
        wait_ps(0, ok);
        capture(12);
        got = pick(0, 0, 12);
        checks++;
        if (!ok || got !== 64'hFE3) begin failures++; $display("FAIL bound_active_low got=%h exp=fe3", got); end
        config_ch(0, 0, 1, 0, 1'b0);
        enable[0] = 1'b1;
        capture(15);
        got = pick(0, 0, 15);
        checks++;
        if (got !== 64'h7FFF) begin failures++; $display("FAIL bound_wl0_pwm got=%h exp=7fff", got); end
        got = pick(0, 1, 15);
        checks++;
        if (got !== 64'h0) begin failures++; $display("FAIL bound_wl0_ps got=%h exp=0", got); end
        do_write(0, 4, 1, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pending[0], wave_length_out, active_high_out} !== {1'b0, 11'd4, 1'b1}) begin
            failures++; $display("FAIL bound_wl0_commit got=%b/%0d/%b exp=0/4/1", pending[0], wave_length_out, active_high_out);
        end
    endtask

    task automatic test_control;
        config_ch(0, 4, 3, 0, 1'b1);
        enable[0] = 1'b1;
        wait_ps(0, ok);
        capture(3);
        got = pick(0, 0, 3);
        checks++;
        if (!ok || got !== 64'h4) begin failures++; $display("FAIL ctrl_pre_disable got=%h exp=4", got); end
        enable[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out[0] !== 1'b0) begin failures++; $display("FAIL ctrl_disable got=%b exp=0", pwm_out[0]); end
        enable = '0;
        do_write(3, 7, 7, 0, 1'b0);
        checks++;
        if ({pending, wave_length_out} !== 14'd0) begin
            failures++; $display("FAIL ctrl_bad_sel got=%b/%0d exp=000/0", pending, wave_length_out);
        end
        ch_sel = 2'd0;
        #1;
        checks++;
        if ({wave_length_out, pulse_width_out, active_high_out} !== {11'd4, 11'd3, 1'b1}) begin
            failures++; $display("FAIL ctrl_bad_sel_ch0 got=%0d/%0d/%b exp=4/3/1", wave_length_out, pulse_width_out, active_high_out);
        end
        config_ch(0, 4, 1, 0, 1'b1);
        enable[0] = 1'b1;
        wait_ps(0, ok);
        capture(3);
        got = pick(0, 0, 3);
        checks++;
        if (!ok || got !== 64'h4) begin failures++; $display("FAIL ctrl_pre_reset got=%h exp=4", got); end
        reset = 1'b1; update = 1'b1; ch_sel = 2'd0;
        wave_length = 11'd9; pulse_width = 11'd9; active_high = 1'b0;
        @(negedge clk);
        checks++;
        if ({pwm_out, period_start, pending} !== 9'b0) begin
            failures++; $display("FAIL ctrl_reset_abort got=%b exp=0", {pwm_out, period_start, pending});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({pending, pwm_out, period_start, wave_length_out, active_high_out} !== 21'd1) begin
            failures++; $display("FAIL ctrl_reset_no_write got=%b/%b/%b/%0d/%b exp=0/0/0/0/1",
                pending, pwm_out, period_start, wave_length_out, active_high_out);
        end
        update = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch_free;
        test_phase;
        test_boundaries;
        test_control;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
